// File: rtl/cc_bus_pkg.sv
// Shared definitions for the parallel host bus initiator and responder.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cc_bus_pkg;

    // Wait-state counter width; WAIT_STATES must fit in it (0..15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_t;

    // Number of cycles the rd/wr strobe is held low.
    function automatic int unsigned strobe_cycles(input int unsigned wait_states);
        return wait_states + 1;
    endfunction

    // Counter load value: the counter sits in STROBE until it reaches zero,
    // so it is loaded with one less than the strobe width.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_states);
        return CNT_W'(strobe_cycles(wait_states) - 1);
    endfunction

endpackage

// File: rtl/cc_wait_counter.sv
// Loadable down-counter with a zero flag, used to time bus strobe widths.
// Latency: load/decrement take effect on the next clock edge; done is combinational from the count.
// Backpressure: none; decrement saturates at zero instead of wrapping.
//
// Ports:
//   clk, reset     clock and synchronous active-low reset (count -> 0)
//   load, load_val load a new count (load has priority over dec)
//   dec            decrement by one when nonzero
//   done           count is zero
module cc_wait_counter
    import cc_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/cc_bus_master.sv
// Parallel host bus initiator: one read/write request becomes a cs/rd/wr strobe sequence.
// Latency: WAIT_STATES+3 cycles per transaction (SETUP, WAIT_STATES+1 STROBE, HOLD), then one IDLE cycle.
// Backpressure: ready=1 only in IDLE; req seen while busy is ignored, no queueing.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   req/wr/addr/wdata           request, sampled when ready=1
//   ready                       idle and able to accept req
//   rdata, rdata_valid          last read data, one-cycle pulse on update
//   bus_addr, bus_dout, bus_din address and data to/from the pad cell
//   bus_oe                      pad drive enable (writes only)
//   bus_cs_n/bus_rd_n/bus_wr_n  active-low bus strobes
module cc_bus_master #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_dout,
    input  logic [DATA_WIDTH-1:0] bus_din,
    output logic                  bus_oe,
    output logic                  bus_cs_n,
    output logic                  bus_rd_n,
    output logic                  bus_wr_n
);
    import cc_bus_pkg::*;

    localparam logic [CNT_W-1:0] LOAD_VAL = wait_load(WAIT_STATES);

    bus_state_t state;
    bus_state_t state_nxt;

    logic cur_wr;
    logic accept;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_done;
    logic wr_eff;
    logic capture;

    logic ready_nxt;
    logic cs_n_nxt;
    logic rd_n_nxt;
    logic wr_n_nxt;
    logic oe_nxt;
    logic rv_nxt;

    cc_wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // Next state plus the next value of every registered output. Outputs are
    // decoded from the state being entered so the pins line up with it.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_load  = 1'b1;
                state_nxt = STROBE;
            end
            STROBE: begin
                if (cnt_done) begin
                    // Edge that ends the last strobe cycle: latch read data.
                    capture   = ~cur_wr;
                    state_nxt = HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Direction of the transaction being entered; on acceptance the
        // captured register has not been written yet.
        wr_eff    = accept ? wr : cur_wr;

        ready_nxt = (state_nxt == IDLE);
        cs_n_nxt  = (state_nxt == IDLE);
        rd_n_nxt  = ~((state_nxt == STROBE) && !wr_eff);
        wr_n_nxt  = ~((state_nxt == STROBE) &&  wr_eff);
        oe_nxt    = (state_nxt != IDLE) && wr_eff;
        rv_nxt    = capture;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cur_wr      <= 1'b0;
            ready       <= 1'b1;
            bus_cs_n    <= 1'b1;
            bus_rd_n    <= 1'b1;
            bus_wr_n    <= 1'b1;
            bus_oe      <= 1'b0;
            bus_addr    <= '0;
            bus_dout    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            ready       <= ready_nxt;
            bus_cs_n    <= cs_n_nxt;
            bus_rd_n    <= rd_n_nxt;
            bus_wr_n    <= wr_n_nxt;
            bus_oe      <= oe_nxt;
            rdata_valid <= rv_nxt;
            if (accept) begin
                cur_wr   <= wr;
                bus_addr <= addr;
                bus_dout <= wdata;
            end
            if (capture) begin
                rdata <= bus_din;
            end
        end
    end

endmodule

// File: tb/tb_cc_bus_master.sv
// Bench for cc_bus_master: WAIT_STATES=2 and WAIT_STATES=0 builds share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_cc_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  bus_din;

    logic        ready       [2];
    logic        rdata_valid [2];
    logic        bus_oe      [2];
    logic        bus_cs_n    [2];
    logic        bus_rd_n    [2];
    logic        bus_wr_n    [2];
    logic [7:0]  rdata       [2];
    logic [7:0]  bus_dout    [2];
    logic [15:0] bus_addr    [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cc_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]),
        .bus_addr(bus_addr[0]), .bus_dout(bus_dout[0]), .bus_din(bus_din),
        .bus_oe(bus_oe[0]), .bus_cs_n(bus_cs_n[0]), .bus_rd_n(bus_rd_n[0]), .bus_wr_n(bus_wr_n[0])
    );

    cc_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]),
        .bus_addr(bus_addr[1]), .bus_dout(bus_dout[1]), .bus_din(bus_din),
        .bus_oe(bus_oe[1]), .bus_cs_n(bus_cs_n[1]), .bus_rd_n(bus_rd_n[1]), .bus_wr_n(bus_wr_n[1])
    );

    // Reference model: each transaction is a cycle index t counted from
    // acceptance. t=1 setup, t=2..ws+2 strobe, t=ws+3 hold, t=0 idle.
    int          t        [2];
    bit          m_wr     [2];
    logic [15:0] m_addr   [2];
    logic [7:0]  m_wdata  [2];
    logic [7:0]  m_rdata  [2];
    bit          m_rst    [2];
    bit          armed = 1'b0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                t[k]       = 0;
                m_rdata[k] = 8'h00;
                m_rst[k]   = 1'b1;
            end else begin
                m_rst[k] = 1'b0;
                if (t[k] == 0) begin
                    if (req) begin
                        t[k]       = 1;
                        m_wr[k]    = wr;
                        m_addr[k]  = addr;
                        m_wdata[k] = wdata;
                    end
                end else begin
                    if (t[k] == ws_of(k) + 2 && !m_wr[k])
                        m_rdata[k] = bus_din;
                    t[k] = (t[k] == ws_of(k) + 3) ? 0 : t[k] + 1;
                end
            end
        end
        if (!reset) armed = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_dut(input int k);
        int  w;
        int  tt;
        bit  strobe;
        string p;
        w      = ws_of(k);
        tt     = t[k];
        strobe = (tt >= 2) && (tt <= w + 2);
        p      = $sformatf("ws%0d", w);
        check_val({p, ".ready"},       32'(ready[k]),       32'(tt == 0));
        check_val({p, ".cs_n"},        32'(bus_cs_n[k]),    32'(tt == 0));
        check_val({p, ".rd_n"},        32'(bus_rd_n[k]),    32'(!(strobe && !m_wr[k])));
        check_val({p, ".wr_n"},        32'(bus_wr_n[k]),    32'(!(strobe && m_wr[k])));
        check_val({p, ".oe"},          32'(bus_oe[k]),      32'(tt != 0 && m_wr[k]));
        check_val({p, ".rdata_valid"}, 32'(rdata_valid[k]), 32'(tt == w + 3 && !m_wr[k]));
        check_val({p, ".rdata"},       32'(rdata[k]),       32'(m_rdata[k]));
        check_val({p, ".strobe_excl"}, 32'(bus_rd_n[k] | bus_wr_n[k]), 32'd1);
        if (m_rst[k]) begin
            check_val({p, ".rst_addr"}, 32'(bus_addr[k]), 32'd0);
            check_val({p, ".rst_dout"}, 32'(bus_dout[k]), 32'd0);
        end else if (tt != 0) begin
            check_val({p, ".bus_addr"}, 32'(bus_addr[k]), 32'(m_addr[k]));
            if (m_wr[k])
                check_val({p, ".bus_dout"}, 32'(bus_dout[k]), 32'(m_wdata[k]));
        end
    endtask

    // One cycle: check outputs settled after the previous edge, then drive
    // the inputs for the next edge.
    task automatic step(input logic rst_n, input logic rq, input logic w,
                        input logic [15:0] a, input logic [7:0] d, input logic [7:0] din);
        @(negedge clk);
        if (armed) begin
            compare_dut(0);
            compare_dut(1);
        end
        reset   = rst_n;
        req     = rq;
        wr      = w;
        addr    = a;
        wdata   = d;
        bus_din = din;
    endtask

    initial begin
        reset   = 1'b0;
        req     = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0;
        wdata   = 8'h0;
        bus_din = 8'h0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);

        // Single write.
        step(1'b1, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00);
        repeat (7) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);

        // Read with a request pulse while busy.
        step(1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C);
        repeat (2) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h3C);
        step(1'b1, 1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h3C);
        repeat (6) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h3C);

        // Back-to-back: req held high, write then read.
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b1, (i < 6), 16'h2000 + 16'(i), 8'h50 + 8'(i), 8'h90 + 8'(i));
        repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);

        // Reset in the second strobe cycle of a read.
        step(1'b1, 1'b1, 1'b0, 16'h0042, 8'h00, 8'h77);
        repeat (2) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h77);
        step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h77);
        repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h77);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 4),
                 1'($urandom),
                 16'($urandom),
                 8'($urandom),
                 8'($urandom));

        step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
